// File: rtl/sobel_gradient.sv
// sobel_gradient: streaming 3x3 Sobel |Gx|+|Gy| magnitude with saturation and edge threshold
// Ports: clk, rst_n (async active-low); pixel_in/pixel_valid/frame_start raster input;
//        threshold edge level; grad_out/edge_out/grad_valid registered result strobe.
module sobel_gradient #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pixel_in,
  input  logic       pixel_valid,
  input  logic       frame_start,
  input  logic [7:0] threshold,
  output logic [7:0] grad_out,
  output logic       edge_out,
  output logic       grad_valid
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state;
  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic accept, last_col, last_row, elig;
  logic [7:0] lb1 [IMG_WIDTH];
  logic [7:0] lb2 [IMG_WIDTH];
  logic [7:0] p [3][3];
  logic signed [11:0] q [3][3];
  logic signed [11:0] gx, gy, ax, ay;
  logic [11:0] mag_c, mag;
  logic [7:0] sat;
  logic s0_valid, s1_valid;
  // frame_start overrides the counters so the current pixel is (0,0)
  assign accept   = pixel_valid && (frame_start || state == ACTIVE);
  assign cur_col  = frame_start ? '0 : col;
  assign cur_row  = frame_start ? '0 : row;
  assign last_col = cur_col == CW'(IMG_WIDTH - 1);
  assign last_row = cur_row == RW'(IMG_HEIGHT - 1);
  assign elig     = accept && cur_row >= RW'(2) && cur_col >= CW'(2);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
    end else if (accept) begin
      col   <= last_col ? '0 : cur_col + 1'b1;
      row   <= last_col ? cur_row + 1'b1 : cur_row;
      state <= (last_col && last_row) ? DONE : ACTIVE;
    end
  end
  // line buffers and window carry data only, so they are left unreset
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[cur_col] <= lb1[cur_col];
      lb1[cur_col] <= pixel_in;
      for (int i = 0; i < 3; i++) begin
        p[i][0] <= p[i][1];
        p[i][1] <= p[i][2];
      end
      p[0][2] <= lb2[cur_col];
      p[1][2] <= lb1[cur_col];
      p[2][2] <= pixel_in;
    end
  end
  always_comb begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        q[i][j] = {4'b0, p[i][j]};
    gx    = (q[0][2] + (q[1][2] <<< 1) + q[2][2]) - (q[0][0] + (q[1][0] <<< 1) + q[2][0]);
    gy    = (q[2][0] + (q[2][1] <<< 1) + q[2][2]) - (q[0][0] + (q[0][1] <<< 1) + q[0][2]);
    ax    = gx[11] ? -gx : gx;
    ay    = gy[11] ? -gy : gy;
    mag_c = ax + ay;
    sat   = |mag[11:8] ? 8'hFF : mag[7:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid   <= 1'b0;
      s1_valid   <= 1'b0;
      mag        <= '0;
      grad_out   <= '0;
      edge_out   <= 1'b0;
      grad_valid <= 1'b0;
    end else begin
      s0_valid   <= elig;
      s1_valid   <= s0_valid;
      grad_valid <= s1_valid;
      if (s0_valid) mag <= mag_c;
      if (s1_valid) begin
        grad_out <= sat;
        edge_out <= sat > threshold;
      end
    end
  end
endmodule

// File: tb/tb_sobel_gradient.sv
// tb_sobel_gradient: scoreboard bench for sobel_gradient against a direct-convolution model
module tb_sobel_gradient;
  localparam int W = 5;
  localparam int H = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] pixel_in = '0;
  logic pixel_valid = 1'b0;
  logic frame_start = 1'b0;
  logic [7:0] threshold = '0;
  logic [7:0] grad_out;
  logic edge_out, grad_valid;
  sobel_gradient #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .frame_start(frame_start), .threshold(threshold), .grad_out(grad_out),
    .edge_out(edge_out), .grad_valid(grad_valid)
  );
  always #5 clk = ~clk;
  typedef struct {int g; bit e; int t;} exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int mr, mc;
  bit mact = 1'b0;
  logic [7:0] img [H][W];
  logic [7:0] fr [H][W];
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int px(int r, int c);
    return int'(img[r][c]);
  endfunction
  function automatic void push_exp(int r, int c);
    int gx, gy, m;
    gx = px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1) - px(r-1,c-1) - 2*px(r,c-1) - px(r+1,c-1);
    gy = px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1) - px(r-1,c-1) - 2*px(r-1,c) - px(r-1,c+1);
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (m > 255) m = 255;
    q.push_back('{m, m > int'(threshold), cyc + 3});
  endfunction
  function automatic void model_accept(logic [7:0] pix, logic fs);
    if (fs) begin
      mact = 1'b1;
      mr = 0;
      mc = 0;
    end
    if (!mact) return;
    img[mr][mc] = pix;
    if (mr >= 2 && mc >= 2) push_exp(mr - 1, mc - 1);
    if (mc == W - 1) begin
      mc = 0;
      if (mr == H - 1) mact = 1'b0;
      else mr++;
    end else mc++;
  endfunction
  always @(negedge clk) begin
    if (rst_n && grad_valid) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL extra_strobe: got grad=%0d edge=%0d at cycle %0d, required no strobe", grad_out, edge_out, cyc);
      end else begin
        e = q.pop_front();
        if (grad_out !== 8'(e.g) || edge_out !== e.e || cyc != e.t) begin
          n_bad++;
          $display("FAIL strobe: got grad=%0d edge=%0d cycle=%0d, required grad=%0d edge=%0d cycle=%0d",
                   grad_out, edge_out, cyc, e.g, e.e, e.t);
        end
      end
    end
  end
  task automatic chk(string n, logic [31:0] a, logic [31:0] b);
    n_cmp++;
    if (a !== b) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", n, a, b);
    end
  endtask
  task automatic drive(logic [7:0] pix, logic v, logic fs);
    @(negedge clk);
    pixel_in = pix;
    pixel_valid = v;
    frame_start = fs;
    if (v) model_accept(pix, fs);
  endtask
  task automatic idle(int n);
    repeat (n) drive(8'($urandom), 1'b0, 1'b0);
  endtask
  task automatic send(int n, int gap);
    for (int k = 0; k < n; k++) begin
      if (gap == 1 || (gap == 2 && $urandom_range(1) == 1)) idle(1);
      drive(fr[k / W][k % W], 1'b1, k == 0);
    end
  endtask
  task automatic fill_cols(logic [7:0] a, logic [7:0] b);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) fr[r][c] = c < 2 ? a : b;
  endtask
  task automatic fill_rand();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) fr[r][c] = 8'($urandom);
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    rst_n = 1'b0;
    q.delete();
    mact = 1'b0;
    #1;
    chk("rst_grad_out", grad_out, 0);
    chk("rst_edge_out", edge_out, 0);
    chk("rst_grad_valid", grad_valid, 0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_valid", grad_valid, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within bound");
    $fatal(1, "watchdog");
  end
  initial begin
    pulse_reset();
    idle(2);
    fill_cols(8'd100, 8'd100);
    send(W * H, 0);
    idle(4);
    threshold = 8'd39;
    fill_cols(8'd10, 8'd20);
    send(W * H, 0);
    idle(4);
    fill_cols(8'd0, 8'd200);
    send(W * H, 0);
    idle(4);
    send(W * H, 1);
    idle(4);
    send(2 * W + 1, 0);
    fill_cols(8'd50, 8'd50);
    send(W * H, 0);
    repeat (5) drive(8'd77, 1'b1, 1'b0);
    idle(4);
    fill_rand();
    send(W * H, 0);
    idle(4);
    fill_rand();
    send(2 * W + 4, 0);
    pulse_reset();
    fill_rand();
    send(W * H, 2);
    idle(4);
    for (int k = 0; k < 6; k++) begin
      threshold = 8'($urandom);
      fill_rand();
      send(W * H, k % 3);
      idle(4);
    end
    fill_rand();
    send(W * H, 0);
    fill_rand();
    send(W * H, 0);
    idle(6);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
